mux_n_scan: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer with manual select and automatic round-robin scan modes. It generalises the team's fixed 4:1 one-bit multiplexer to arbitrary channel count and data width. It adds a registered output, a dwell counter that time-division-multiplexes all channels onto one bus, and a wrap indicator. It sits between the input-capture blocks and any single-bus consumer, such as a display driver or serial logger, that samples one channel at a time.

---
 rtl/mux_n_scan.sv | 161 ++++++++++++++++
 tb/tb_mux_n_scan.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_scan.sv
// mux_n_scan: N-channel, W-bit registered multiplexer with two modes.
//   Manual mode (MODE=0) presents channel SEL on S.
//   Scan mode (MODE=1) steps round-robin through channels 0..N-1 and
//   holds each channel for DWELL enabled cycles.
//   All outputs are registered, so there is one cycle from input sample to output.
//
// Ports:
//   clk    in   1         rising-edge clock
//   rst    in   1         asynchronous active-high reset
//   I      in   N*W       channel data; channel k is I[k*W +: W]
//   SEL    in   SELW      manual channel select (used only when MODE=0)
//   MODE   in   1         0 = manual, 1 = scan
//   EN     in   1         update enable; 0 freezes state and drops VALID
//   S      out  W         registered selected data
//   CH     out  SELW      index of the channel currently on S
//   VALID  out  1         S/CH were freshly captured from an in-range channel
//   WRAP   out  1         pulse on the final dwell sample of channel N-1
module mux_n_scan #(
  parameter int N     = 8,
  parameter int W     = 4,
  parameter int DWELL = 4,
  localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*W-1:0]    I,
  input  logic [SELW-1:0]   SEL,
  input  logic              MODE,
  input  logic              EN,
  output logic [W-1:0]      S,
  output logic [SELW-1:0]   CH,
  output logic              VALID,
  output logic              WRAP
);

  localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [SELW-1:0] PTR_LAST   = SELW'(N - 1);
  localparam logic [SELW-1:0] PTR_ONE    = SELW'(1);
  // One bit wider than SEL so that N itself is representable.
  localparam logic [SELW:0]   CHAN_COUNT = (SELW + 1)'(N);
  localparam logic [CNTW-1:0] CNT_LAST   = CNTW'(DWELL - 1);
  localparam logic [CNTW-1:0] CNT_ONE    = CNTW'(1);

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [SELW-1:0]   ptr_q,   ptr_d;
  logic [CNTW-1:0]   cnt_q,   cnt_d;
  logic [W-1:0]      s_q,     s_d;
  logic [SELW-1:0]   ch_q,    ch_d;
  logic              valid_q, valid_d;
  logic              wrap_q,  wrap_d;

  logic [SELW-1:0]   ptr_eff;
  logic [CNTW-1:0]   cnt_eff;
  logic              sel_ok;
  logic              dwell_done;
  logic              at_last;

  // Extract channel idx from the concatenated input bus.
  function automatic logic [W-1:0] pick_channel(input logic [N*W-1:0] data,
                                                input logic [SELW-1:0] idx);
    return data[idx*W +: W];
  endfunction

  // While in manual, the stored scan position is ignored, so a fresh entry
  // into scan always begins at channel 0 with a full dwell window.
  assign ptr_eff    = (state_q == ST_SCAN) ? ptr_q : '0;
  assign cnt_eff    = (state_q == ST_SCAN) ? cnt_q : '0;
  assign sel_ok     = ({1'b0, SEL} < CHAN_COUNT);
  assign dwell_done = (cnt_eff == CNT_LAST);
  assign at_last    = (ptr_eff == PTR_LAST);

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_MANUAL;
      ptr_q   <= '0;
      cnt_q   <= '0;
      s_q     <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next-state logic: mode tracking plus scan pointer and dwell counter.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (EN) begin
      if (MODE) begin
        state_d = ST_SCAN;
        if (dwell_done) begin
          cnt_d = '0;
          ptr_d = at_last ? '0 : (ptr_eff + PTR_ONE);
        end else begin
          cnt_d = cnt_eff + CNT_ONE;
          ptr_d = ptr_eff;
        end
      end else begin
        state_d = ST_MANUAL;
        ptr_d   = '0;
        cnt_d   = '0;
      end
    end else begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
    end
  end

  // Output logic: next values for the registered S/CH/VALID/WRAP.
  always_comb begin
    s_d     = s_q;
    ch_d    = ch_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    if (EN) begin
      if (MODE) begin
        s_d     = pick_channel(I, ptr_eff);
        ch_d    = ptr_eff;
        valid_d = 1'b1;
        wrap_d  = dwell_done & at_last;
      end else if (sel_ok) begin
        s_d     = pick_channel(I, SEL);
        ch_d    = SEL;
        valid_d = 1'b1;
      end else begin
        // Out-of-range select: blank the data but keep the last channel index.
        s_d     = '0;
        ch_d    = ch_q;
        valid_d = 1'b0;
      end
    end else begin
      s_d     = s_q;
      ch_d    = ch_q;
      valid_d = 1'b0;
      wrap_d  = 1'b0;
    end
  end

  assign S     = s_q;
  assign CH    = ch_q;
  assign VALID = valid_q;
  assign WRAP  = wrap_q;

endmodule

// File: tb/tb_mux_n_scan.sv
module tb_mux_n_scan;

  localparam int NP = 8;
  localparam int WP = 4;
  localparam int DP = 4;

  logic        clk = 1'b0;
  logic        rst;

  // Main instance: N=8, W=4, DWELL=4
  logic [31:0] I_m;
  logic [2:0]  SEL_m;
  logic        MODE_m, EN_m;
  logic [3:0]  S_m;
  logic [2:0]  CH_m;
  logic        VALID_m, WRAP_m;

  // Corner instance: N=5, W=1, DWELL=1
  logic [4:0]  I_c;
  logic [2:0]  SEL_c;
  logic        MODE_c, EN_c;
  logic [0:0]  S_c;
  logic [2:0]  CH_c;
  logic        VALID_c, WRAP_c;

  int total = 0;
  int bad   = 0;

  mux_n_scan #(.N(NP), .W(WP), .DWELL(DP)) dut_m (
    .clk(clk), .rst(rst), .I(I_m), .SEL(SEL_m), .MODE(MODE_m), .EN(EN_m),
    .S(S_m), .CH(CH_m), .VALID(VALID_m), .WRAP(WRAP_m)
  );

  mux_n_scan #(.N(5), .W(1), .DWELL(1)) dut_c (
    .clk(clk), .rst(rst), .I(I_c), .SEL(SEL_c), .MODE(MODE_c), .EN(EN_c),
    .S(S_c), .CH(CH_c), .VALID(VALID_c), .WRAP(WRAP_c)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WP-1:0] chan(input logic [NP*WP-1:0] d, input int k);
    return d[k*WP +: WP];
  endfunction

  // Behavioural model: scan position is a single count of enabled scan
  // cycles since scan was entered; channel = (pos / DWELL) mod N.
  logic [3:0] m_s;
  int         m_ch;
  bit         m_v, m_w;
  bit         m_scan;
  int         m_pos;
  int         a_pos;
  assign a_pos = m_scan ? m_pos : 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s <= 4'd0; m_ch <= 0; m_v <= 1'b0; m_w <= 1'b0; m_scan <= 1'b0; m_pos <= 0;
    end else if (!EN_m) begin
      m_v <= 1'b0;
      m_w <= 1'b0;
    end else if (MODE_m) begin
      m_ch   <= (a_pos / DP) % NP;
      m_s    <= chan(I_m, (a_pos / DP) % NP);
      m_v    <= 1'b1;
      m_w    <= (a_pos == NP * DP - 1);
      m_pos  <= (a_pos + 1) % (NP * DP);
      m_scan <= 1'b1;
    end else begin
      m_scan <= 1'b0;
      m_pos  <= 0;
      m_w    <= 1'b0;
      if (int'(SEL_m) < NP) begin
        m_s  <= chan(I_m, int'(SEL_m));
        m_ch <= int'(SEL_m);
        m_v  <= 1'b1;
      end else begin
        m_s  <= 4'd0;
        m_v  <= 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison of the main instance against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("cmp_S",     32'(S_m),     32'(m_s));
      check("cmp_CH",    32'(CH_m),    32'(m_ch));
      check("cmp_VALID", 32'(VALID_m), 32'(m_v));
      check("cmp_WRAP",  32'(WRAP_m),  32'(m_w));
    end
  end

  initial begin
    int exp_s;
    bit found;
    rst = 1'b1;
    I_m = 32'h8765_4321;   // channel k holds k+1
    SEL_m = 3'd0; MODE_m = 1'b0; EN_m = 1'b0;
    I_c = 5'b10101;        // channel k holds (k+1) mod 2
    SEL_c = 3'd0; MODE_c = 1'b0; EN_c = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_S", 32'(S_m), 0);
    check("reset_CH", 32'(CH_m), 0);
    check("reset_VALID", 32'(VALID_m), 0);
    check("reset_WRAP", 32'(WRAP_m), 0);
    rst = 1'b0;

    // Manual select of channel 5
    MODE_m = 1'b0; EN_m = 1'b1; SEL_m = 3'd5;
    cyc();
    check("man_S", 32'(S_m), 6);
    check("man_CH", 32'(CH_m), 5);
    check("man_VALID", 32'(VALID_m), 1);
    check("model_man_S", 32'(m_s), 6);

    // Asynchronous reset between edges
    rst = 1'b1;
    #2;
    check("arst_S", 32'(S_m), 0);
    check("arst_CH", 32'(CH_m), 0);
    check("arst_VALID", 32'(VALID_m), 0);
    rst = 1'b0;

    // Full scan: 32 cycles then back to channel 0
    MODE_m = 1'b1; EN_m = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      cyc();
      exp_s = (c <= 32) ? ((c - 1) / 4 + 1) : 1;
      check("scan_S", 32'(S_m), 32'(exp_s));
      check("scan_CH", 32'(CH_m), 32'(exp_s - 1));
      check("scan_WRAP", 32'(WRAP_m), (c == 32) ? 1 : 0);
      if (c == 32) check("model_wrap", 32'(m_w), 1);
    end

    // Enable stall at channel 3 after 2 dwell cycles
    MODE_m = 1'b0; SEL_m = 3'd0;
    cyc();
    MODE_m = 1'b1;
    repeat (14) cyc();
    check("stall_pre_S", 32'(S_m), 4);
    EN_m = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("stall_S", 32'(S_m), 4);
      check("stall_VALID", 32'(VALID_m), 0);
    end
    EN_m = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("resume_S", 32'(S_m), (k < 2) ? 4 : 5);
      check("resume_VALID", 32'(VALID_m), 1);
    end

    // Mode switching: scan to channel 6, go manual, re-enter scan
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      cyc();
      if (CH_m == 3'd6) found = 1'b1;
    end
    check("reach_ch6", 32'(found), 1);
    MODE_m = 1'b0; SEL_m = 3'd2;
    cyc();
    check("sw_man_S", 32'(S_m), 3);
    MODE_m = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("sw_scan_S", 32'(S_m), (k < 4) ? 1 : 2);
    end

    // Corner instance: N=5, DWELL=1
    MODE_c = 1'b1; EN_c = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      check("c_CH", 32'(CH_c), 32'((c - 1) % 5));
      check("c_S", 32'(S_c), (((c - 1) % 5) % 2 == 0) ? 1 : 0);
      check("c_WRAP", 32'(WRAP_c), (c % 5 == 0) ? 1 : 0);
    end
    MODE_c = 1'b0; SEL_c = 3'd2;
    cyc();
    check("c_man_S", 32'(S_c), 1);
    check("c_man_CH", 32'(CH_c), 2);
    SEL_c = 3'd6;
    cyc();
    check("c_oor_S", 32'(S_c), 0);
    check("c_oor_VALID", 32'(VALID_c), 0);
    check("c_oor_CH", 32'(CH_c), 2);

    // Async reset during a WRAP cycle
    MODE_c = 1'b1;
    repeat (5) cyc();
    check("c_wrap_pre", 32'(WRAP_c), 1);
    rst = 1'b1;
    #1;
    check("c_arst_WRAP", 32'(WRAP_c), 0);
    check("c_arst_VALID", 32'(VALID_c), 0);
    check("c_arst_S", 32'(S_c), 0);
    #1;
    rst = 1'b0;
    cyc();
    check("post_rst_CH", 32'(CH_m), 0);
    check("post_rst_S", 32'(S_m), 1);
    EN_c = 1'b0;

    // Randomised run checked by the model
    for (int k = 0; k < 600; k++) begin
      MODE_m = ($urandom_range(0, 3) != 0);
      EN_m   = ($urandom_range(0, 4) != 0);
      SEL_m  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) I_m = $urandom;
      cyc();
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        #2;
        rst = 1'b0;
      end
    end
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
